// File: rtl/ppu_sprite_pattern_fetch.sv
// Sprite pattern fetch: reads CHR planes for the two line-selected sprite
// slots of one 8-pixel tile, then streams 8 resolved sprite pixels.
module ppu_sprite_pattern_fetch #(
  parameter int unsigned CHR_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tile_start,
  input  logic [8:0]  curr_row,
  input  logic [8:0]  curr_col,
  input  logic        pt_sel,
  input  logic        s0_on,
  input  logic        s1_on,
  input  logic [7:0]  s0_tile,
  input  logic [7:0]  s1_tile,
  input  logic [7:0]  s0_row,
  input  logic [7:0]  s1_row,
  input  logic [7:0]  s0_col,
  input  logic [7:0]  s1_col,
  input  logic [7:0]  s0_attr,
  input  logic [7:0]  s1_attr,
  input  logic        s0_is0,
  input  logic        s1_is0,
  output logic [12:0] chr_addr,
  output logic        chr_rd,
  input  logic [7:0]  chr_data,
  output logic        pix_valid,
  output logic [1:0]  sp_color,
  output logic [1:0]  sp_pal,
  output logic        sp_behind,
  output logic        sp_zero,
  output logic        busy,
  output logic        done
);

  localparam int unsigned ADDR_W = 13;
  localparam int unsigned X_W    = 10;

  typedef enum logic [2:0] {IDLE, LATCH, RD, CAP, OUT} state_t;

  // Only a one-clock CHR read latency is handled by the RD/CAP pairing.
  if (CHR_LAT != 1) begin : g_lat_check
    $error("ppu_sprite_pattern_fetch supports only CHR_LAT == 1");
  end

  state_t               state, state_d;
  logic [2:0]           px, px_d;
  logic [1:0]           ridx, ridx_d;
  logic [3:0]           pend, pend_d, list;
  logic [1:0][7:0]      lo_q, hi_q, lo_d, hi_d;

  logic [8:0]           ccol_q;
  logic [2:0]           crow_q;
  logic                 pt_q;
  logic [1:0]           on_q, vflip_q, hflip_q, behind_q, is0_q;
  logic [1:0][7:0]      tile_q, scol_q;
  logic [1:0][2:0]      srow_q;
  logic [1:0][1:0]      pal_q;

  logic                 slot;
  logic [2:0]           fy;
  logic [ADDR_W-1:0]    addr_d;
  logic [X_W-1:0]       x, off0, off1;
  logic [1:0]           pix0, pix1;
  logic                 rd_d, pv_d, behind_d, zero_d, busy_d, done_d;
  logic [1:0]           color_d, pal_d;

  logic                 unused_bits;
  assign unused_bits = ^{curr_row[8:3], s0_row[7:3], s1_row[7:3], s0_attr[4:2], s1_attr[4:2]};

  // Lowest pending read in list order: s0 lo, s0 hi, s1 lo, s1 hi.
  function automatic logic [1:0] first_set(input logic [3:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else if (m[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  // Pattern colour of one slot at signed offset off from its left edge.
  function automatic logic [1:0] pix_color(input logic [X_W-1:0] off, input logic hflip,
                                           input logic [7:0] lo, input logic [7:0] hi);
    logic [2:0] b;
    b = hflip ? off[2:0] : ~off[2:0];
    if (off[X_W-1:3] != '0) return 2'b00;
    return {hi[b], lo[b]};
  endfunction

  // Capture the tile's sprite slots and position when a tile is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ccol_q <= '0; crow_q <= '0; pt_q <= 1'b0;
      on_q <= '0; vflip_q <= '0; hflip_q <= '0; behind_q <= '0; is0_q <= '0;
      tile_q <= '0; scol_q <= '0; srow_q <= '0; pal_q <= '0;
    end else if (state == IDLE && tile_start) begin
      ccol_q   <= curr_col;
      crow_q   <= curr_row[2:0];
      pt_q     <= pt_sel;
      on_q     <= {s1_on, s0_on};
      vflip_q  <= {s1_attr[7], s0_attr[7]};
      hflip_q  <= {s1_attr[6], s0_attr[6]};
      behind_q <= {s1_attr[5], s0_attr[5]};
      is0_q    <= {s1_is0, s0_is0};
      tile_q   <= {s1_tile, s0_tile};
      scol_q   <= {s1_col, s0_col};
      srow_q   <= {s1_row[2:0], s0_row[2:0]};
      pal_q    <= {s1_attr[1:0], s0_attr[1:0]};
    end
  end

  // Next state, pattern capture and next registered outputs.
  always_comb begin
    state_d = state;
    px_d    = px;
    ridx_d  = ridx;
    pend_d  = pend;
    lo_d    = lo_q;
    hi_d    = hi_q;
    list    = {on_q[1], on_q[1], on_q[0], on_q[0]};

    case (state)
      IDLE: begin
        if (tile_start) begin
          state_d = LATCH;
          lo_d    = '0;
          hi_d    = '0;
        end
      end
      LATCH: begin
        if (list == '0) begin
          state_d = OUT;
          px_d    = '0;
        end else begin
          state_d = RD;
          ridx_d  = first_set(list);
          pend_d  = list & ~(4'b0001 << first_set(list));
        end
      end
      RD: state_d = CAP;
      CAP: begin
        if (ridx[0]) hi_d[ridx[1]] = chr_data;
        else         lo_d[ridx[1]] = chr_data;
        if (pend != '0) begin
          state_d = RD;
          ridx_d  = first_set(pend);
          pend_d  = pend & ~(4'b0001 << first_set(pend));
        end else begin
          state_d = OUT;
          px_d    = '0;
        end
      end
      OUT: begin
        px_d = px + 3'd1;
        if (px == 3'd7) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    slot   = ridx_d[1];
    fy     = crow_q - srow_q[slot];
    if (vflip_q[slot]) fy = ~fy;
    addr_d = chr_addr;
    rd_d   = (state_d == RD);
    if (rd_d) addr_d = {pt_q, tile_q[slot], ridx_d[0], fy};

    x    = {ccol_q[8], ccol_q} + X_W'(px_d);
    off0 = x - {2'b00, scol_q[0]};
    off1 = x - {2'b00, scol_q[1]};
    pix0 = pix_color(off0, hflip_q[0], lo_d[0], hi_d[0]);
    pix1 = pix_color(off1, hflip_q[1], lo_d[1], hi_d[1]);

    pv_d     = (state_d == OUT);
    done_d   = pv_d && (px_d == 3'd7);
    busy_d   = (state_d != IDLE);
    color_d  = 2'b00;
    pal_d    = 2'b00;
    behind_d = 1'b0;
    zero_d   = 1'b0;
    if (pv_d) begin
      if (pix0 != 2'b00) begin
        color_d = pix0; pal_d = pal_q[0]; behind_d = behind_q[0]; zero_d = is0_q[0];
      end else if (pix1 != 2'b00) begin
        color_d = pix1; pal_d = pal_q[1]; behind_d = behind_q[1]; zero_d = is0_q[1];
      end
    end
  end

  // State, pattern planes and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE; px <= '0; ridx <= '0; pend <= '0; lo_q <= '0; hi_q <= '0;
      chr_addr <= '0; chr_rd <= 1'b0; pix_valid <= 1'b0; sp_color <= '0; sp_pal <= '0;
      sp_behind <= 1'b0; sp_zero <= 1'b0; busy <= 1'b0; done <= 1'b0;
    end else begin
      state <= state_d; px <= px_d; ridx <= ridx_d; pend <= pend_d; lo_q <= lo_d; hi_q <= hi_d;
      chr_addr <= addr_d; chr_rd <= rd_d; pix_valid <= pv_d; sp_color <= color_d;
      sp_pal <= pal_d; sp_behind <= behind_d; sp_zero <= zero_d; busy <= busy_d; done <= done_d;
    end
  end

endmodule

// File: tb/tb_ppu_sprite_pattern_fetch.sv
// Bench for ppu_sprite_pattern_fetch: directed vector table, abort sequence,
// and randomized tiles checked against an arithmetic reference model.
module tb_ppu_sprite_pattern_fetch;

  typedef struct packed {
    logic       on0, on1;
    logic [7:0] tile0, tile1, row0, row1, col0, col1, attr0, attr1;
    logic       is00, is01;
    logic [8:0] crow, ccol;
    logic       pt;
  } tile_t;

  typedef struct packed {
    tile_t            s;
    logic [2:0]       n;
    logic [3:0][12:0] a;
    logic [3:0][7:0]  d;
    logic [15:0]      col;
    logic [15:0]      pal;
    logic [7:0]       beh;
    logic [7:0]       zr;
  } vec_t;

  localparam int TW = $bits(tile_t);

  logic        clk = 1'b0;
  logic        rst, tile_start, pt_sel;
  logic [8:0]  curr_row, curr_col;
  logic        s0_on, s1_on, s0_is0, s1_is0;
  logic [7:0]  s0_tile, s1_tile, s0_row, s1_row, s0_col, s1_col, s0_attr, s1_attr;
  logic [12:0] chr_addr;
  logic        chr_rd;
  logic [7:0]  chr_data = 8'h00;
  logic        pix_valid, sp_behind, sp_zero, busy, done;
  logic [1:0]  sp_color, sp_pal;

  logic [7:0]  mem [0:8191];
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  ppu_sprite_pattern_fetch #(.CHR_LAT(1)) dut (
    .clk(clk), .rst(rst), .tile_start(tile_start), .curr_row(curr_row), .curr_col(curr_col),
    .pt_sel(pt_sel), .s0_on(s0_on), .s1_on(s1_on), .s0_tile(s0_tile), .s1_tile(s1_tile),
    .s0_row(s0_row), .s1_row(s1_row), .s0_col(s0_col), .s1_col(s1_col),
    .s0_attr(s0_attr), .s1_attr(s1_attr), .s0_is0(s0_is0), .s1_is0(s1_is0),
    .chr_addr(chr_addr), .chr_rd(chr_rd), .chr_data(chr_data), .pix_valid(pix_valid),
    .sp_color(sp_color), .sp_pal(sp_pal), .sp_behind(sp_behind), .sp_zero(sp_zero),
    .busy(busy), .done(done)
  );

  // CHR memory with one clock of latency; junk on the bus when no read is due.
  logic        rd_due = 1'b0;
  logic [12:0] rd_addr = 13'h0;
  always @(negedge clk) begin
    if (rd_due) chr_data = mem[rd_addr];
    else        chr_data = 8'($urandom);
    rd_due  = chr_rd;
    rd_addr = chr_addr;
  end

  function automatic logic [31:0] outs();
    return {9'b0, chr_rd, (chr_rd ? chr_addr : 13'h0), pix_valid, sp_color, sp_pal,
            sp_behind, sp_zero, busy, done};
  endfunction

  function automatic logic [31:0] pack(input logic rd, input logic [12:0] a, input logic pv,
                                       input logic [1:0] c, input logic [1:0] p,
                                       input logic b, input logic z, input logic bz, input logic d);
    return {9'b0, rd, a, pv, c, p, b, z, bz, d};
  endfunction

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, exp);
    end
  endtask

  function automatic tile_t mkt(input logic on0, input logic [7:0] tile0, row0, col0, attr0, input logic is00,
                                input logic on1, input logic [7:0] tile1, row1, col1, attr1, input logic is01,
                                input logic [8:0] crow, ccol, input logic pt);
    tile_t s;
    s.on0 = on0; s.tile0 = tile0; s.row0 = row0; s.col0 = col0; s.attr0 = attr0; s.is00 = is00;
    s.on1 = on1; s.tile1 = tile1; s.row1 = row1; s.col1 = col1; s.attr1 = attr1; s.is01 = is01;
    s.crow = crow; s.ccol = ccol; s.pt = pt;
    return s;
  endfunction

  function automatic vec_t mkv(input tile_t s, input int n, input logic [12:0] a0, a1, a2, a3,
                               input logic [7:0] d0, d1, d2, d3, input logic [15:0] col, pal,
                               input logic [7:0] beh, zr);
    vec_t v;
    v.s = s; v.n = 3'(n); v.a = {a3, a2, a1, a0}; v.d = {d3, d2, d1, d0};
    v.col = col; v.pal = pal; v.beh = beh; v.zr = zr;
    return v;
  endfunction

  task automatic apply_inputs(input tile_t s);
    s0_on = s.on0; s0_tile = s.tile0; s0_row = s.row0; s0_col = s.col0; s0_attr = s.attr0; s0_is0 = s.is00;
    s1_on = s.on1; s1_tile = s.tile1; s1_row = s.row1; s1_col = s.col1; s1_attr = s.attr1; s1_is0 = s.is01;
    curr_row = s.crow; curr_col = s.ccol; pt_sel = s.pt;
  endtask

  // Reference: read list and pixels straight from the arithmetic rules.
  task automatic model(input tile_t s, output vec_t v);
    int n, fy, addr, xs, off, b, win;
    logic [7:0] lo [2];
    logic [7:0] hi [2];
    logic [7:0] tl, rw, cl, at;
    logic [1:0] cs [2];
    v = '0; v.s = s; n = 0;
    for (int sl = 0; sl < 2; sl++) begin
      lo[sl] = 8'h00; hi[sl] = 8'h00;
      tl = sl == 0 ? s.tile0 : s.tile1;
      rw = sl == 0 ? s.row0 : s.row1;
      at = sl == 0 ? s.attr0 : s.attr1;
      if (sl == 0 ? s.on0 : s.on1) begin
        fy = (int'(s.crow) - int'(rw)) & 7;
        if (at[7]) fy = 7 - fy;
        for (int pl = 0; pl < 2; pl++) begin
          addr = int'(s.pt) * 4096 + int'(tl) * 16 + pl * 8 + fy;
          v.a[n] = 13'(addr);
          v.d[n] = mem[addr];
          if (pl == 0) lo[sl] = mem[addr]; else hi[sl] = mem[addr];
          n++;
        end
      end
    end
    v.n = 3'(n);
    xs = int'(s.ccol) >= 256 ? int'(s.ccol) - 512 : int'(s.ccol);
    for (int p = 0; p < 8; p++) begin
      for (int sl = 0; sl < 2; sl++) begin
        cl  = sl == 0 ? s.col0 : s.col1;
        at  = sl == 0 ? s.attr0 : s.attr1;
        off = xs + p - int'(cl);
        cs[sl] = 2'b00;
        if (off >= 0 && off <= 7) begin
          b = at[6] ? off : 7 - off;
          cs[sl] = {hi[sl][b], lo[sl][b]};
        end
      end
      win = cs[0] != 2'b00 ? 0 : (cs[1] != 2'b00 ? 1 : -1);
      if (win == 0) begin
        v.col[2*p +: 2] = cs[0]; v.pal[2*p +: 2] = s.attr0[1:0]; v.beh[p] = s.attr0[5]; v.zr[p] = s.is00;
      end else if (win == 1) begin
        v.col[2*p +: 2] = cs[1]; v.pal[2*p +: 2] = s.attr1[1:0]; v.beh[p] = s.attr1[5]; v.zr[p] = s.is01;
      end
    end
  endtask

  // One tile from a negedge: start pulse, then a per-cycle check of every output.
  task automatic run_tile(input string name, input vec_t v, input bit scramble);
    int first;
    int p;
    tile_t junk;
    logic erd, epv;
    logic [12:0] ea;
    first = 2 + 2 * int'(v.n);
    apply_inputs(v.s);
    tile_start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= first + 8; c++) begin
      @(negedge clk);
      erd = (c % 2 == 0) && c >= 2 && c <= 2 * int'(v.n);
      ea  = erd ? v.a[(c - 2) / 2] : 13'h0;
      epv = c >= first && c <= first + 7;
      p   = epv ? c - first : 0;
      chk(name, c, outs(),
          pack(erd, ea, epv, epv ? v.col[2*p +: 2] : 2'b00, epv ? v.pal[2*p +: 2] : 2'b00,
               epv & v.beh[p], epv & v.zr[p], c <= first + 7, c == first + 7));
      tile_start = 1'b0;
      if (scramble && c + 1 <= first + 7) begin
        junk = TW'({$urandom, $urandom, $urandom});
        apply_inputs(junk);
        tile_start = 1'($urandom);
      end
    end
    tile_start = 1'b0;
  endtask

  vec_t  vecs [8];
  vec_t  v;
  tile_t s;

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
    apply_inputs('0);
    tile_start = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset", 0, outs(), 32'h0);
    rst = 1'b1;
    @(negedge clk);

    s = mkt(1'b1, 8'h12, 8'd10, 8'd16, 8'h01, 1'b0, 1'b0, 8'h00, 8'd0, 8'd0, 8'h00, 1'b0, 9'd13, 9'd16, 1'b0);
    vecs[0] = mkv(s, 2, 13'h0123, 13'h012B, 13'h0, 13'h0, 8'h81, 8'h01, 8'h00, 8'h00, 16'hC001, 16'h4001, 8'h00, 8'h00);
    s = mkt(1'b1, 8'h12, 8'd10, 8'd16, 8'hC0, 1'b0, 1'b0, 8'h00, 8'd0, 8'd0, 8'h00, 1'b0, 9'd10, 9'd16, 1'b1);
    vecs[1] = mkv(s, 2, 13'h1127, 13'h112F, 13'h0, 13'h0, 8'h01, 8'h00, 8'h00, 8'h00, 16'h0001, 16'h0000, 8'h00, 8'h00);
    s = mkt(1'b1, 8'h01, 8'd0, 8'd16, 8'h22, 1'b1, 1'b1, 8'h02, 8'd0, 8'd16, 8'h03, 1'b0, 9'd0, 9'd16, 1'b0);
    vecs[2] = mkv(s, 4, 13'h0010, 13'h0018, 13'h0020, 13'h0028, 8'hFF, 8'h00, 8'hFF, 8'hFF, 16'h5555, 16'hAAAA, 8'hFF, 8'hFF);
    vecs[3] = mkv(s, 4, 13'h0010, 13'h0018, 13'h0020, 13'h0028, 8'h00, 8'h00, 8'hFF, 8'hFF, 16'hFFFF, 16'hFFFF, 8'h00, 8'h00);
    s = mkt(1'b1, 8'h12, 8'd10, 8'd20, 8'h01, 1'b0, 1'b0, 8'h00, 8'd0, 8'd0, 8'h00, 1'b0, 9'd13, 9'd16, 1'b0);
    vecs[4] = mkv(s, 2, 13'h0123, 13'h012B, 13'h0, 13'h0, 8'hF0, 8'h80, 8'h00, 8'h00, 16'h5700, 16'h5500, 8'h00, 8'h00);
    s = mkt(1'b1, 8'h12, 8'd10, 8'd0, 8'h01, 1'b0, 1'b0, 8'h00, 8'd0, 8'd0, 8'h00, 1'b0, 9'd13, 9'h1FC, 1'b0);
    vecs[5] = mkv(s, 2, 13'h0123, 13'h012B, 13'h0, 13'h0, 8'hF0, 8'h80, 8'h00, 8'h00, 16'h5700, 16'h5500, 8'h00, 8'h00);
    s = mkt(1'b0, 8'h12, 8'd10, 8'd16, 8'h01, 1'b1, 1'b0, 8'h12, 8'd10, 8'd16, 8'h01, 1'b0, 9'd13, 9'd16, 1'b0);
    vecs[6] = mkv(s, 0, 13'h0, 13'h0, 13'h0, 13'h0, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 16'h0000, 8'h00, 8'h00);
    s = mkt(1'b0, 8'h12, 8'd10, 8'd16, 8'h01, 1'b1, 1'b1, 8'h34, 8'd5, 8'd0, 8'h41, 1'b0, 9'd7, 9'd0, 1'b0);
    vecs[7] = mkv(s, 2, 13'h0342, 13'h034A, 13'h0, 13'h0, 8'h0F, 8'h03, 8'h00, 8'h00, 16'h005F, 16'h0055, 8'h00, 8'h00);

    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < int'(vecs[i].n); k++) mem[vecs[i].a[k]] = vecs[i].d[k];
      run_tile($sformatf("vec%0d", i), vecs[i], i == 2);
    end

    // Abort during the second read, then a fresh tile.
    s = TW'({$urandom, $urandom, $urandom});
    s.on0 = 1'b1; s.on1 = 1'b1;
    apply_inputs(s);
    tile_start = 1'b1;
    @(posedge clk);
    #1 tile_start = 1'b0;
    repeat (4) @(negedge clk);
    chk("rd2_before_abort", 4, 32'(chr_rd), 32'h1);
    rst = 1'b0;
    #1 chk("abort", 4, outs(), 32'h0);
    @(negedge clk);
    chk("abort_hold", 5, outs(), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    model(s, v);
    run_tile("after_abort", v, 1'b0);

    for (int i = 0; i < 40; i++) begin
      s = TW'({$urandom, $urandom, $urandom});
      s.on0 = $urandom_range(0, 3) != 0;
      s.on1 = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 1) == 1) s.col0 = 8'(int'(s.ccol) + int'($urandom_range(0, 14)) - 7);
      if ($urandom_range(0, 1) == 1) s.col1 = 8'(int'(s.ccol) + int'($urandom_range(0, 14)) - 7);
      model(s, v);
      run_tile($sformatf("rand%0d", i), v, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
